// File: rtl/adc_decim_pkg.sv
// adc_decim_pkg: reduction mode codes and controller state encoding for the ADC decimator.
package adc_decim_pkg;
  localparam logic [1:0] MODE_MAX     = 2'd0;
  localparam logic [1:0] MODE_MIN     = 2'd1;
  localparam logic [1:0] MODE_FIRST   = 2'd2;
  localparam logic [1:0] MODE_ABSPEAK = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;
endpackage

// File: rtl/adc_lane_pack.sv
// adc_lane_pack: packs DATA_W results into OUT_W words, lane 0 in the LSBs; flush emits a partial word marked last.
module adc_lane_pack #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 32,
  localparam int LANES = OUT_W / DATA_W,
  localparam int LW    = $clog2(LANES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_vld,
  output logic              o_last,
  output logic [LW-1:0]     o_lanes
);
  logic [OUT_W-1:0] r_buf;
  logic [LW-1:0]    r_cnt;
  logic [OUT_W-1:0] w_buf;
  logic             w_full;

  assign w_buf  = r_buf | (i_wr ? OUT_W'(i_data) << (r_cnt * DATA_W) : '0);
  assign w_full = i_wr && (r_cnt == LW'(LANES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf   <= '0;
      r_cnt   <= '0;
      o_data  <= '0;
      o_vld   <= 1'b0;
      o_last  <= 1'b0;
      o_lanes <= '0;
    end else begin
      o_vld <= 1'b0;
      if (i_clr) begin
        r_buf <= '0;
        r_cnt <= '0;
      end else if (w_full) begin
        o_data  <= w_buf;
        o_lanes <= LW'(LANES);
        o_last  <= 1'b0;
        o_vld   <= 1'b1;
        r_buf   <= '0;
        r_cnt   <= '0;
      end else if (i_wr) begin
        r_buf <= w_buf;
        r_cnt <= r_cnt + 1'b1;
      end else if (i_flush && r_cnt != '0) begin
        o_data  <= r_buf;
        o_lanes <= r_cnt;
        o_last  <= 1'b1;
        o_vld   <= 1'b1;
        r_buf   <= '0;
        r_cnt   <= '0;
      end
    end
  end
endmodule

// File: rtl/adc_decim.sv
// adc_decim: reduces each window of i_ratio ADC samples to one value (max/min/first/abs-peak) and packs the results into words.
module adc_decim
  import adc_decim_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RATIO_W = 8,
  parameter int OUT_W   = 32,
  localparam int LANES  = OUT_W / DATA_W,
  localparam int LW     = $clog2(LANES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_sync,
  input  logic [DATA_W-1:0]  i_adc_data,
  input  logic [RATIO_W-1:0] i_ratio,
  input  logic [1:0]         i_mode,
  input  logic               i_complite,
  output logic [OUT_W-1:0]   o_out_data,
  output logic               o_out_vld,
  output logic               o_out_last,
  output logic [LW-1:0]      o_out_lanes
);
  state_t             r_state, w_next;
  logic [RATIO_W-1:0] r_ratio, r_wcnt;
  logic [1:0]         r_mode;
  logic [DATA_W-1:0]  r_acc, r_res;
  logic               r_vld, r_pend;
  logic [RATIO_W-1:0] w_eff_ratio, w_cnt_nx;
  logic [DATA_W-1:0]  w_fold;
  logic               w_run, w_done, w_flush;

  // Magnitude needs one extra bit so the most negative sample outranks everything.
  function automatic logic [DATA_W:0] mag(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? -{x[DATA_W-1], x} : {1'b0, x};
  endfunction

  assign w_eff_ratio = (i_ratio == '0) ? RATIO_W'(1) : i_ratio;
  assign w_cnt_nx    = r_wcnt + 1'b1;
  assign w_done      = w_cnt_nx == r_ratio;
  assign w_run       = r_state == ST_RUN && !i_complite;
  assign w_fold = (r_wcnt == '0) ? i_adc_data :
                  (r_mode == MODE_MAX) ? ((i_adc_data > r_acc) ? i_adc_data : r_acc) :
                  (r_mode == MODE_MIN) ? ((i_adc_data < r_acc) ? i_adc_data : r_acc) :
                  (r_mode == MODE_ABSPEAK && mag(i_adc_data) > mag(r_acc)) ? i_adc_data : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // A result still being packed on the complite cycle delays the flush by one cycle.
  always_comb begin
    w_next  = r_state;
    w_flush = 1'b0;
    if (i_sync) w_next = ST_RUN;
    else if (r_state == ST_RUN && i_complite) w_next = ST_FLUSH;
    else if (r_state == ST_FLUSH && !r_pend) begin
      w_next  = ST_IDLE;
      w_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ratio <= '0;
      r_wcnt  <= '0;
      r_mode  <= '0;
      r_acc   <= '0;
      r_res   <= '0;
      r_vld   <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_vld  <= 1'b0;
      r_pend <= !i_sync && r_state == ST_RUN && i_complite && r_vld;
      if (i_sync) begin
        r_ratio <= w_eff_ratio;
        r_mode  <= i_mode;
        r_acc   <= i_adc_data;
        r_res   <= i_adc_data;
        r_vld   <= w_eff_ratio == RATIO_W'(1);
        r_wcnt  <= (w_eff_ratio == RATIO_W'(1)) ? '0 : RATIO_W'(1);
      end else if (w_run) begin
        if (w_done) begin
          r_res  <= w_fold;
          r_vld  <= 1'b1;
          r_wcnt <= '0;
        end else begin
          r_acc  <= w_fold;
          r_wcnt <= w_cnt_nx;
        end
      end
    end
  end

  adc_lane_pack #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (i_sync),
    .i_wr    (r_vld && !i_sync),
    .i_data  (r_res),
    .i_flush (w_flush),
    .o_data  (o_out_data),
    .o_vld   (o_out_vld),
    .o_last  (o_out_last),
    .o_lanes (o_out_lanes)
  );
endmodule

// File: tb/tb_adc_decim.sv
// tb_adc_decim: directed vector table, hand sequences and randomized captures against a window/pack reference model.
module tb_adc_decim;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        i_sync = 0;
  logic [7:0]  i_adc_data = 0;
  logic [7:0]  i_ratio = 0;
  logic [1:0]  i_mode = 0;
  logic        i_complite = 0;
  logic [31:0] o_out_data;
  logic        o_out_vld;
  logic        o_out_last;
  logic [2:0]  o_out_lanes;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  l;
    logic        last;
    int          t;
  } word_t;

  typedef struct {
    logic [1:0]   m;
    logic [7:0]   r;
    int           n;
    logic [127:0] s;
    int           words;
    logic [31:0]  d;
    logic [2:0]   l;
    logic         last;
    int           dt;
  } vec_t;

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         t_last, t_cpl;
  word_t      obs[$];
  logic [7:0] smp[$];
  vec_t       vt[7];

  adc_decim #(.DATA_W(8), .RATIO_W(8), .OUT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sync      (i_sync),
    .i_adc_data  (i_adc_data),
    .i_ratio     (i_ratio),
    .i_mode      (i_mode),
    .i_complite  (i_complite),
    .o_out_data  (o_out_data),
    .o_out_vld   (o_out_vld),
    .o_out_last  (o_out_last),
    .o_out_lanes (o_out_lanes)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (o_out_vld === 1'b1) obs.push_back('{o_out_data, o_out_lanes, o_out_last, cyc});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int absv(input logic [7:0] x);
    int v = int'($signed(x));
    return v < 0 ? -v : v;
  endfunction

  task automatic run_cap(input logic [1:0] m, input logic [7:0] r, input bit cs);
    obs.delete();
    i_sync = 1; i_complite = cs; i_mode = m; i_ratio = r; i_adc_data = smp[0];
    t_last = cyc;
    tick();
    i_sync = 0; i_complite = 0;
    for (int k = 1; k < smp.size(); k++) begin
      i_ratio = 8'($urandom); i_mode = 2'($urandom); i_adc_data = smp[k];
      t_last = cyc;
      tick();
    end
    i_complite = 1; i_adc_data = 8'($urandom);
    t_cpl = cyc;
    tick();
    i_complite = 0;
    repeat (5) tick();
  endtask

  task automatic compare_model(input logic [1:0] m, input logic [7:0] r, input string tag);
    int         eff;
    logic [7:0] res[$];
    word_t      exp[$];
    eff = (r == 0) ? 1 : int'(r);
    for (int w = 0; (w + 1) * eff <= smp.size(); w++) begin
      int         b = w * eff;
      logic [7:0] v = smp[b];
      for (int j = b + 1; j < b + eff; j++) begin
        if (m == 2'd0 && smp[j] > v) v = smp[j];
        if (m == 2'd1 && smp[j] < v) v = smp[j];
        if (m == 2'd3 && absv(smp[j]) > absv(v)) v = smp[j];
      end
      res.push_back(v);
    end
    for (int i = 0; i < res.size(); i += 4) begin
      word_t x = '{32'd0, 3'd0, 1'b0, 0};
      for (int k = 0; k < 4 && i + k < res.size(); k++) begin
        x.d[8*k +: 8] = res[i+k];
        x.l++;
      end
      x.last = x.l != 3'd4;
      exp.push_back(x);
    end
    chk({tag, " model word count"}, obs.size(), exp.size());
    for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
      chk($sformatf("%s model data[%0d]", tag, i), obs[i].d, exp[i].d);
      chk($sformatf("%s model lanes[%0d]", tag, i), obs[i].l, exp[i].l);
      chk($sformatf("%s model last[%0d]", tag, i), obs[i].last, exp[i].last);
    end
  endtask

  initial begin
    word_t w;
    vt[0] = '{2'd0, 8'd4, 16, 128'h0F0E0D0C0B0A09080706050403020100, 1, 32'h0F0B0703, 3'd4, 1'b0, 2};
    vt[1] = '{2'd1, 8'd3, 6, 128'h010707050209, 1, 32'h00000102, 3'd2, 1'b1, 3};
    vt[2] = '{2'd3, 8'd2, 6, 128'hFD037F80F905, 1, 32'h000380F9, 3'd3, 1'b1, 3};
    vt[3] = '{2'd2, 8'd0, 8, 128'h8877665544332211, 2, 32'h88776655, 3'd4, 1'b0, 2};
    vt[4] = '{2'd2, 8'd1, 5, 128'h0504030201, 2, 32'h00000005, 3'd1, 1'b1, 3};
    vt[5] = '{2'd0, 8'd3, 7, 128'h090304051E140A, 1, 32'h0000051E, 3'd2, 1'b1, 2};
    vt[6] = '{2'd3, 8'd4, 4, 128'h0180817F, 1, 32'h00000080, 3'd1, 1'b1, 3};

    repeat (2) tick();
    chk("reset data", o_out_data, 0);
    chk("reset vld", o_out_vld, 0);
    chk("reset last", o_out_last, 0);
    chk("reset lanes", o_out_lanes, 0);
    rst_n = 1;
    tick();

    for (int i = 0; i < 7; i++) begin
      smp.delete();
      for (int k = 0; k < vt[i].n; k++) smp.push_back(vt[i].s[8*k +: 8]);
      run_cap(vt[i].m, vt[i].r, 1'b0);
      w = (obs.size() > 0) ? obs[obs.size()-1] : '{32'hDEAD, 3'd7, 1'bx, -99};
      chk($sformatf("vec%0d words", i), obs.size(), vt[i].words);
      chk($sformatf("vec%0d data", i), w.d, vt[i].d);
      chk($sformatf("vec%0d lanes", i), w.l, vt[i].l);
      chk($sformatf("vec%0d last", i), w.last, vt[i].last);
      chk($sformatf("vec%0d latency", i), w.t - (vt[i].last ? t_cpl : t_last), vt[i].dt);
      compare_model(vt[i].m, vt[i].r, $sformatf("vec%0d", i));
    end

    // Resync after two packed results and one in flight: only post-sync lanes survive.
    obs.delete();
    i_mode = 2'd2; i_ratio = 8'd1;
    i_sync = 1; i_adc_data = 8'hA1; tick();
    i_sync = 0; i_adc_data = 8'hA2; tick();
    i_adc_data = 8'hA3; tick();
    i_sync = 1; i_adc_data = 8'hB0; tick();
    i_sync = 0;
    for (int k = 1; k < 4; k++) begin
      i_adc_data = 8'hB0 + 8'(k);
      tick();
    end
    i_complite = 1; tick();
    i_complite = 0; repeat (5) tick();
    w = (obs.size() > 0) ? obs[0] : '{32'hDEAD, 3'd7, 1'bx, -99};
    chk("resync words", obs.size(), 1);
    chk("resync data", w.d, 32'hB3B2B1B0);
    chk("resync lanes", w.l, 3'd4);
    chk("resync last", w.last, 1'b0);

    // Reset mid-window, then sync and complite together.
    i_mode = 2'd0; i_ratio = 8'd4;
    i_sync = 1; i_adc_data = 8'h33; tick();
    i_sync = 0; tick();
    rst_n = 0;
    #2;
    chk("midrst data", o_out_data, 0);
    chk("midrst vld", o_out_vld, 0);
    chk("midrst last", o_out_last, 0);
    chk("midrst lanes", o_out_lanes, 0);
    tick();
    rst_n = 1;
    tick();
    chk("post-rst data", o_out_data, 0);
    smp.delete();
    for (int k = 0; k < 8; k++) smp.push_back(8'($urandom));
    run_cap(2'd0, 8'd2, 1'b1);
    compare_model(2'd0, 8'd2, "sync+complite");

    for (int n = 0; n < 30; n++) begin
      logic [1:0] m;
      logic [7:0] r;
      int         len;
      m = 2'($urandom_range(0, 3));
      r = 8'($urandom_range(0, 6));
      len = $urandom_range(1, 40);
      smp.delete();
      for (int k = 0; k < len; k++) begin
        int p = $urandom_range(0, 7);
        smp.push_back(p == 0 ? 8'h80 : p == 1 ? 8'h7F : p == 2 ? 8'h81 : 8'($urandom));
      end
      run_cap(m, r, 1'b0);
      compare_model(m, r, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/adc_decim.md
# adc_decim

Parametrised ADC decimator and word packer for the scope front end. After an `i_sync` pulse it reduces each window of `i_ratio` consecutive ADC samples to one value, using a run-time selected mode (max, min, first-sample or signed absolute peak). It packs the reduced values into `OUT_W`-bit words for the capture FIFO. `i_complite` ends a capture and flushes any partially filled word, marked as last.

## Interface
Parameters:
- `DATA_W`, 8 — ADC sample width; also the width of one packed lane.
- `RATIO_W`, 8 — width of `i_ratio`.
- `OUT_W`, 32 — output word width. Must be an integer multiple of `DATA_W`. `LANES = OUT_W/DATA_W`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  — system clock, all logic on rising edge.
- `rst_n`  in  1  — asynchronous active-low reset.
- `i_sync`  in  1  — capture start; one-cycle pulse.
- `i_adc_data`  in  `DATA_W`  — ADC sample; one valid sample every clock.
- `i_ratio`  in  `RATIO_W`  — samples per window. A value of 0 is treated as 1.
- `i_mode`  in  2  — reduction mode: 0 MAX (unsigned), 1 MIN (unsigned), 2 FIRST (first sample of the window), 3 ABSPEAK (two's-complement sample of largest magnitude).
- `i_complite`  in  1  — capture end; one-cycle pulse.
- `o_out_data`  out  `OUT_W`  — packed word. Lane 0 (the earliest result) occupies the LSBs.
- `o_out_vld`  out  1  — one-cycle strobe for `o_out_data`.
- `o_out_last`  out  1  — qualifies `o_out_vld`: this is the final word of the capture.
- `o_out_lanes`  out  `$clog2(LANES+1)`  — number of valid lanes in the word (`LANES` unless the word is a flush).

## Operation
- States: IDLE, RUN, FLUSH.
- **Reset:** state IDLE. All outputs are 0; all counters and the accumulator are cleared.
- **`i_sync` (any state):**
  - Latch `i_ratio` (0→1) and `i_mode`.
  - Load the accumulator with this cycle's `i_adc_data` and set the window count to 1.
  - Clear the lane count, discarding any partial word or in-flight result.
  - Go to RUN.
- **RUN, per cycle:**
  - The sample is folded into the accumulator using the latched mode.
  - In ABSPEAK, ties keep the earlier sample. −2^(DATA_W−1) counts as the largest magnitude.
  - When the window count reaches the ratio, the folded value (including this sample) is registered as result `r` with `r_vld=1` on the next cycle.
  - The next sample then starts a new window.
  - Ratio 1 means every sample is a result.
- **Packer:**
  - Each `r_vld` writes `r` into lane `lane_cnt` and increments `lane_cnt`.
  - When the write fills lane `LANES−1`: assert `o_out_vld` on the next cycle with `o_out_lanes=LANES`, `o_out_last=0`, and reset `lane_cnt` to 0.
- **`i_complite` in RUN:**
  - The sample in that cycle is not consumed, and a partial window is discarded.
  - A result with `r_vld` high in that cycle is still packed.
  - Then FLUSH for one cycle: if `lane_cnt>0`, emit the word with unused lanes zero, `o_out_lanes=lane_cnt`, `o_out_last=1`.
  - If `lane_cnt==0` and the last full word was already emitted, emit nothing; a capture can end without a word marked `o_out_last`.
  - Go to IDLE.
- `i_complite` in IDLE has no effect.
- If `i_sync` and `i_complite` occur in the same cycle, `i_sync` wins and no flush occurs.
- Changes to `i_ratio` or `i_mode` during RUN are ignored until the next `i_sync`.

## Timing
- Result latency: `r_vld` is high 1 cycle after the last sample of a window.
- Full word: `o_out_vld` is high 2 cycles after the last sample of the window that fills the word.
- Flush word: `o_out_vld` with `o_out_last` is high 2 cycles after `i_complite`, or 3 if an `r_vld` was pending in the `i_complite` cycle.
- Throughput: 1 sample per clock, no backpressure. The consumer must accept one word per cycle in the worst case (`LANES=1`, ratio 1).
- Counters are `RATIO_W` bits. The window counter never wraps because it resets at the ratio.
- `o_out_data`, `o_out_lanes` and `o_out_last` are held between strobes and return to 0 only on reset.

## Structure
- Package `adc_decim_pkg`: mode constants `MODE_MAX/MIN/FIRST/ABSPEAK` and the state encoding.
- Sub-module `adc_lane_pack`: a `DATA_W`→`OUT_W` lane packer with clear (driven by sync), write, and flush inputs, which produces the word, strobe, last flag and lane count.
- The reduction logic and window counter stay in the top module.

## Test plan
- MAX, ratio 4, `DATA_W=8`, `OUT_W=32`, ramp 0..15 after sync → one word `0x0F0B0703`, `o_out_lanes=4`, strobe 2 cycles after sample 15.
- MIN, ratio 3, samples 9,2,5,7,7,1 → results 2,1. Then `i_complite` → flush word `0x00000102`, `o_out_last=1`, `o_out_lanes=2`.
- ABSPEAK, ratio 2, pairs (0x05,0xF9),(0x80,0x7F),(0x03,0xFD) → results 0xF9, 0x80, 0x03 (tie keeps the earlier sample).
- FIRST, ratio 0 (treated as 1) → every sample passes through; a 32-bit word every 4 cycles.
- Reissue `i_sync` after 2 results are packed → partial lanes discarded; the next word holds only post-sync results.
- Assert `rst_n=0` mid-window, then `i_sync` and `i_complite` in the same cycle → all outputs 0 during reset; afterwards RUN is entered and no flush occurs.
